// File: rtl/systolic_mm_stream_loader_pkg.sv
// Shared types and width helpers for the systolic matrix-multiplier loader.
//   loader_state_t : sequencer states, in visiting order
//   idx_width()    : width of the row-major element index for an order-N matrix
//   cnt_width()    : width of a counter that must hold the value 'cycles'
// Both helpers return at least 1 so that degenerate parameter values still
// produce legal vector widths.
package systolic_pkg;

   typedef enum logic [2:0] {
      LOAD_A,
      LOAD_B,
      CLEAR,
      COMPUTE,
      DRAIN
   } loader_state_t;

   function automatic int idx_width(input int size);
      return ($clog2(size * size) < 1) ? 1 : $clog2(size * size);
   endfunction

   function automatic int cnt_width(input int cycles);
      return ($clog2(cycles + 1) < 1) ? 1 : $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/systolic_mm_stream_loader_serializer.sv
// mm_result_serializer
//   Holds the captured product matrix and presents it one element at a time,
//   row-major, on a valid/ready stream.
// Ports
//   clock, nreset  : clock and synchronous active-low reset
//   capture        : register prod into the result store this cycle
//   drain_en       : sequencer is in its drain phase (drives out_valid)
//   idx            : current row-major element index owned by the sequencer
//   prod           : product matrix from the array
//   out_ready      : downstream accepts the presented element
//   out_valid      : element valid
//   out_data       : element value, registered so it holds outside drain
//   out_last       : high with the final element
module mm_result_serializer
   import systolic_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SIZE  = 3,
   parameter int IDX_W = 4
) (
   input  logic             clock,
   input  logic             nreset,
   input  logic             capture,
   input  logic             drain_en,
   input  logic [IDX_W-1:0] idx,
   input  logic [WIDTH-1:0] prod [SIZE][SIZE],
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_last
);

   localparam int NELEM = SIZE * SIZE;

   logic [WIDTH-1:0] result_reg [NELEM];
   logic [WIDTH-1:0] data_reg;
   logic [WIDTH-1:0] data_next;
   logic [IDX_W-1:0] idx_inc;
   logic             last_w;

   assign idx_inc   = idx + 1'b1;
   assign last_w    = (idx == IDX_W'(NELEM - 1));
   assign out_valid = drain_en;
   assign out_last  = drain_en && last_w;
   assign out_data  = data_reg;

   always_ff @(posedge clock) begin
      if (!nreset) begin
         for (int e = 0; e < NELEM; e++) begin
            result_reg[e] <= '0;
         end
      end else if (capture) begin
         for (int e = 0; e < NELEM; e++) begin
            result_reg[e] <= prod[e / SIZE][e % SIZE];
         end
      end
   end

   // out_data is registered one element ahead: the first element is taken
   // straight from prod on capture, and each accepted non-final element
   // preloads its successor. After the final handshake the value is simply
   // held, which keeps out_data stable outside the drain phase.
   always_comb begin
      data_next = data_reg;
      if (capture) begin
         data_next = prod[0][0];
      end else if (drain_en && out_ready && !last_w) begin
         data_next = result_reg[idx_inc];
      end
   end

   always_ff @(posedge clock) begin
      if (!nreset) begin
         data_reg <= '0;
      end else begin
         data_reg <= data_next;
      end
   end

endmodule

// File: rtl/systolic_mm_stream_loader.sv
// systolic_mm_stream_loader
//   Sequencer around a systolic matrix multiplier: loads A then B from an
//   operand stream, restarts the array, waits a fixed compute window,
//   captures the product and streams it out row-major.
// Ports
//   clock, nreset        : clock and synchronous active-low reset
//   in_valid/in_ready    : operand stream handshake; in_data is row-major, A then B
//   a_matrix, b_matrix   : registered operand drive to the array
//   array_nreset         : active-low array restart
//   prod                 : product matrix from the array
//   out_valid/out_ready  : result stream handshake
//   out_data, out_last   : result element and final-element flag
//   busy                 : high whenever the loader is not waiting for A
module systolic_mm_stream_loader
   import systolic_pkg::*;
#(
   parameter int WIDTH          = 16,
   parameter int SIZE           = 3,
   parameter int WIDTHx         = 4,
   parameter int COMPUTE_CYCLES = 10
) (
   input  logic              clock,
   input  logic              nreset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTHx-1:0] in_data,
   output logic [WIDTHx-1:0] a_matrix [SIZE][SIZE],
   output logic [WIDTHx-1:0] b_matrix [SIZE][SIZE],
   output logic              array_nreset,
   input  logic [WIDTH-1:0]  prod [SIZE][SIZE],
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  out_data,
   output logic              out_last,
   output logic              busy
);

   localparam int NELEM = SIZE * SIZE;
   localparam int IDX_W = idx_width(SIZE);
   localparam int CNT_W = cnt_width(COMPUTE_CYCLES);

   loader_state_t    state_reg, state_next;
   logic [IDX_W-1:0] idx_reg, idx_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             in_hs;
   logic             out_hs;
   logic             idx_last;
   logic             capture;
   logic             drain_en;

   assign in_ready     = (state_reg == LOAD_A) || (state_reg == LOAD_B);
   assign in_hs        = in_valid && in_ready;
   assign out_hs       = out_valid && out_ready;
   assign idx_last     = (idx_reg == IDX_W'(NELEM - 1));
   assign drain_en     = (state_reg == DRAIN);
   assign busy         = (state_reg != LOAD_A);
   // Combining with nreset keeps the array in reset whenever the loader is.
   assign array_nreset = nreset && (state_reg != CLEAR);

   always_comb begin
      state_next = state_reg;
      idx_next   = idx_reg;
      cnt_next   = cnt_reg;
      capture    = 1'b0;
      case (state_reg)
         LOAD_A: begin
            if (in_hs) begin
               if (idx_last) begin
                  idx_next   = '0;
                  state_next = LOAD_B;
               end else begin
                  idx_next = idx_reg + 1'b1;
               end
            end
         end
         LOAD_B: begin
            if (in_hs) begin
               if (idx_last) begin
                  idx_next   = '0;
                  state_next = CLEAR;
               end else begin
                  idx_next = idx_reg + 1'b1;
               end
            end
         end
         CLEAR: begin
            cnt_next   = '0;
            state_next = COMPUTE;
         end
         COMPUTE: begin
            if (cnt_reg == CNT_W'(COMPUTE_CYCLES - 1)) begin
               capture    = 1'b1;
               state_next = DRAIN;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         DRAIN: begin
            if (out_hs) begin
               if (idx_last) begin
                  idx_next   = '0;
                  state_next = LOAD_A;
               end else begin
                  idx_next = idx_reg + 1'b1;
               end
            end
         end
         default: begin
            state_next = LOAD_A;
            idx_next   = '0;
            cnt_next   = '0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!nreset) begin
         state_reg <= LOAD_A;
         idx_reg   <= '0;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         idx_reg   <= idx_next;
         cnt_reg   <= cnt_next;
      end
   end

   // Operand stores: only written by a handshake in their own load state,
   // so they stay frozen through CLEAR, COMPUTE and DRAIN.
   always_ff @(posedge clock) begin
      if (!nreset) begin
         for (int r = 0; r < SIZE; r++) begin
            for (int c = 0; c < SIZE; c++) begin
               a_matrix[r][c] <= '0;
               b_matrix[r][c] <= '0;
            end
         end
      end else if (in_hs) begin
         for (int r = 0; r < SIZE; r++) begin
            for (int c = 0; c < SIZE; c++) begin
               if (idx_reg == IDX_W'(r * SIZE + c)) begin
                  if (state_reg == LOAD_A) begin
                     a_matrix[r][c] <= in_data;
                  end else begin
                     b_matrix[r][c] <= in_data;
                  end
               end
            end
         end
      end
   end

   mm_result_serializer #(
      .WIDTH (WIDTH),
      .SIZE  (SIZE),
      .IDX_W (IDX_W)
   ) u_serializer (
      .clock     (clock),
      .nreset    (nreset),
      .capture   (capture),
      .drain_en  (drain_en),
      .idx       (idx_reg),
      .prod      (prod),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last)
   );

endmodule

// File: tb/tb_systolic_mm_stream_loader.sv
// Bench for systolic_mm_stream_loader with a registered behavioural array
// model. Expected products are computed from the operands as they are sent
// and queued; the drain task pops and compares each accepted result.
module tb_systolic_mm_stream_loader;

   localparam int WIDTH  = 16;
   localparam int SIZE   = 3;
   localparam int WIDTHx = 4;
   localparam int CC     = 10;
   localparam int NE     = SIZE * SIZE;

   logic              clock = 1'b0;
   logic              nreset = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [WIDTHx-1:0] in_data = '0;
   logic [WIDTHx-1:0] a_matrix [SIZE][SIZE];
   logic [WIDTHx-1:0] b_matrix [SIZE][SIZE];
   logic              array_nreset;
   logic [WIDTH-1:0]  prod [SIZE][SIZE];
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [WIDTH-1:0]  out_data;
   logic              out_last;
   logic              busy;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int last_b_cyc = 0;
   int ma [NE];
   int mb [NE];

   typedef struct {
      int   d;
      logic l;
   } exp_t;
   exp_t sb [$];

   systolic_mm_stream_loader #(
      .WIDTH          (WIDTH),
      .SIZE           (SIZE),
      .WIDTHx         (WIDTHx),
      .COMPUTE_CYCLES (CC)
   ) dut (
      .clock        (clock),
      .nreset       (nreset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .a_matrix     (a_matrix),
      .b_matrix     (b_matrix),
      .array_nreset (array_nreset),
      .prod         (prod),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_last     (out_last),
      .busy         (busy)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // Array model: one-cycle registered matrix product, cleared while restarted.
   always @(posedge clock) begin
      for (int r = 0; r < SIZE; r++) begin
         for (int c = 0; c < SIZE; c++) begin
            int s;
            s = 0;
            for (int k = 0; k < SIZE; k++) begin
               s += int'(a_matrix[r][k]) * int'(b_matrix[k][c]);
            end
            prod[r][c] <= array_nreset ? WIDTH'(s) : '0;
         end
      end
   end

   task automatic send_elem(input int v, input int gap);
      int w;
      w = 0;
      in_data  = WIDTHx'(v);
      in_valid = 1'b1;
      @(negedge clock);
      while (!in_ready && w < 100) begin
         @(negedge clock);
         w++;
      end
      if (w >= 100) begin
         total++;
         bad++;
         $display("FAIL in_accept_timeout: in_ready=%0b required=1", in_ready);
      end
      @(posedge clock);
      #1;
      if (gap > 0) begin
         in_valid = 1'b0;
         repeat (gap) @(posedge clock);
         #1;
      end
   endtask

   // Sends ma then mb and queues the expected product. keep_valid leaves
   // in_valid high with data 0xF after the final B element.
   task automatic load_pair(input int gap, input bit keep_valid);
      exp_t e;
      for (int i = 0; i < NE; i++) send_elem(ma[i], gap);
      for (int i = 0; i < NE; i++) send_elem(mb[i], (i == NE - 1) ? 0 : gap);
      last_b_cyc = cyc;
      if (keep_valid) begin
         in_valid = 1'b1;
         in_data  = 4'hF;
      end else begin
         in_valid = 1'b0;
      end
      for (int r = 0; r < SIZE; r++) begin
         for (int c = 0; c < SIZE; c++) begin
            e.d = 0;
            for (int k = 0; k < SIZE; k++) e.d += ma[r * SIZE + k] * mb[k * SIZE + c];
            e.l = (r == SIZE - 1) && (c == SIZE - 1);
            sb.push_back(e);
         end
      end
   endtask

   task automatic drain(input bit bp, input bit check_lat, input bit hold_in);
      int   n, k, guard;
      bit   seen, stalled;
      logic [WIDTH-1:0] pd;
      logic pl;
      exp_t e;
      n = 0; k = 0; guard = 0; seen = 0; stalled = 0; pd = '0; pl = 1'b0;
      while (n < NE && guard < 500) begin
         out_ready = bp ? (k % 3 == 0) : 1'b1;
         @(negedge clock);
         if (out_valid) begin
            if (!seen) begin
               seen = 1;
               if (check_lat) begin
                  total++;
                  if ((cyc - last_b_cyc) !== CC + 1) begin
                     bad++;
                     $display("FAIL latency: got=%0d required=%0d", cyc - last_b_cyc, CC + 1);
                  end
               end
            end
            k++;
            if (stalled) begin
               total++;
               if (out_data !== pd || out_last !== pl) begin
                  bad++;
                  $display("FAIL stall_stable: data=%0d last=%0b required data=%0d last=%0b",
                           out_data, out_last, pd, pl);
               end
            end
            if (out_ready) begin
               total++;
               if (sb.size() == 0) begin
                  bad++;
                  $display("FAIL unexpected_output: data=%0d required=none", out_data);
               end else begin
                  e = sb.pop_front();
                  if (out_data !== WIDTH'(e.d) || out_last !== e.l) begin
                     bad++;
                     $display("FAIL result[%0d]: data=%0d last=%0b required data=%0d last=%0b",
                              n, out_data, out_last, e.d, e.l);
                  end else begin
                     $display("result[%0d] data=%0d last=%0b", n, out_data, out_last);
                  end
               end
               n++;
               stalled = 0;
            end else begin
               stalled = 1;
               pd = out_data;
               pl = out_last;
            end
         end else if (hold_in) begin
            total++;
            if (in_ready !== 1'b0 || a_matrix[SIZE-1][SIZE-1] !== WIDTHx'(ma[NE-1])
                || b_matrix[0][0] !== WIDTHx'(mb[0])) begin
               bad++;
               $display("FAIL ignore_compute: in_ready=%0b a22=%0d b00=%0d required 0 %0d %0d",
                        in_ready, a_matrix[SIZE-1][SIZE-1], b_matrix[0][0], ma[NE-1], mb[0]);
            end
         end
         @(posedge clock);
         #1;
         guard++;
      end
      if (guard >= 500) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: handshakes=%0d required=%0d", n, NE);
      end
      out_ready = 1'b0;
      in_valid  = 1'b0;
      @(negedge clock);
      total++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || out_last !== 1'b0) begin
         bad++;
         $display("FAIL post_drain: out_valid=%0b busy=%0b in_ready=%0b out_last=%0b required 0 0 1 0",
                  out_valid, busy, in_ready, out_last);
      end
      @(posedge clock);
      #1;
   endtask

   task automatic set_identity();
      for (int i = 0; i < NE; i++) begin
         ma[i] = i + 1;
         mb[i] = (i % (SIZE + 1) == 0) ? 1 : 0;
      end
   endtask

   task automatic test_reset();
      nreset = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      total++;
      if (array_nreset !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== '0
          || busy !== 1'b0 || in_ready !== 1'b1 || a_matrix[1][1] !== '0) begin
         bad++;
         $display("FAIL reset_state: arst=%0b ov=%0b ol=%0b od=%0d busy=%0b ir=%0b a11=%0d required 0 0 0 0 0 1 0",
                  array_nreset, out_valid, out_last, out_data, busy, in_ready, a_matrix[1][1]);
      end
      @(posedge clock);
      #1;
      nreset = 1'b1;
      $display("reset checked");
   endtask

   task automatic test_identity();
      set_identity();
      load_pair(0, 0);
      @(negedge clock);
      total++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
         bad++;
         $display("FAIL load_done: in_ready=%0b busy=%0b required 0 1", in_ready, busy);
      end
      drain(0, 1, 0);
   endtask

   task automatic test_max_operands();
      for (int i = 0; i < NE; i++) begin
         ma[i] = 15;
         mb[i] = 15;
      end
      load_pair(0, 0);
      drain(0, 1, 0);
   endtask

   task automatic test_backpressure();
      set_identity();
      load_pair(0, 0);
      drain(1, 1, 0);
   endtask

   task automatic test_input_gaps();
      set_identity();
      load_pair(3, 0);
      drain(0, 1, 0);
   endtask

   task automatic test_reset_mid();
      set_identity();
      for (int i = 0; i < NE; i++) send_elem(ma[i], 0);
      for (int i = 0; i < 5; i++) send_elem(mb[i], 0);
      in_valid = 1'b0;
      nreset   = 1'b0;
      @(negedge clock);
      total++;
      if (array_nreset !== 1'b0) begin
         bad++;
         $display("FAIL mid_reset_array: array_nreset=%0b required 0", array_nreset);
      end
      @(posedge clock);
      #1;
      nreset = 1'b1;
      @(negedge clock);
      total++;
      if (a_matrix[0][0] !== '0 || a_matrix[2][2] !== '0 || b_matrix[0][0] !== '0
          || busy !== 1'b0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL mid_reset_state: a00=%0d a22=%0d b00=%0d busy=%0b ir=%0b required 0 0 0 0 1",
                  a_matrix[0][0], a_matrix[2][2], b_matrix[0][0], busy, in_ready);
      end
      @(posedge clock);
      #1;
      for (int i = 0; i < NE; i++) begin
         ma[i] = (3 * i + 2) % 16;
         mb[i] = (NE - i) % 16;
      end
      load_pair(0, 0);
      drain(0, 1, 0);
   endtask

   task automatic test_ignore_compute();
      set_identity();
      load_pair(0, 1);
      drain(0, 1, 1);
   endtask

   initial begin
      test_reset();
      test_identity();
      test_max_operands();
      test_backpressure();
      test_input_gaps();
      test_reset_mid();
      test_ignore_compute();
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_left: entries=%0d required=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
